// File: rtl/cache_meta_array.sv
// rtl/cache_meta_array.sv - valid/tag/dirty/LRU metadata store with flush sequencer
module cache_meta_array #(
    parameter int SETS  = 128,
    parameter int WAYS  = 4,
    parameter int TAG_W = 11
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic [$clog2(SETS)-1:0]         index,
    input  logic [$clog2(WAYS)-1:0]         way_sel,
    input  logic                            valid_update,
    input  logic [TAG_W-1:0]                cache_tag_update,
    input  logic                            dirty_bit_update,
    input  logic                            update_lru,
    output logic [SETS*WAYS-1:0]            valid,
    output logic [TAG_W-1:0]                cache_tag [SETS*WAYS-1:0],
    output logic [SETS*WAYS-1:0]            dirty_bits,
    output logic [$clog2(WAYS)-1:0]         age [SETS*WAYS-1:0],
    input  logic                            flush_req,
    output logic                            flush_valid,
    output logic [$clog2(SETS*WAYS)-1:0]    flush_index,
    output logic [TAG_W-1:0]                flush_tag,
    input  logic                            flush_ready,
    output logic                            busy,
    output logic                            flush_done
);

    localparam int N     = SETS * WAYS;
    localparam int WAY_W = $clog2(WAYS);
    localparam int PTR_W = $clog2(N);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(N - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [WAY_W-1:0] AGE_ONE = WAY_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        WAIT_WB = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic             clr_valid, clr_dirty;
    logic [PTR_W-1:0] entry;
    logic [WAY_W-1:0] age_old;

    assign entry   = {index, way_sel};
    assign age_old = age[entry];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        clr_valid   = 1'b0;
        clr_dirty   = 1'b0;
        flush_valid = 1'b0;
        flush_index = '0;
        flush_tag   = '0;
        busy        = 1'b1;
        flush_done  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (flush_req) begin
                    state_nxt = SCAN;
                    ptr_nxt   = '0;
                end
            end
            SCAN: begin
                if (valid[ptr] && dirty_bits[ptr]) begin
                    state_nxt = WAIT_WB;
                end else begin
                    clr_valid = 1'b1;
                    if (ptr == LAST) state_nxt = DONE;
                    else             ptr_nxt   = ptr + PTR_ONE;
                end
            end
            WAIT_WB: begin
                flush_valid = 1'b1;
                flush_index = ptr;
                flush_tag   = cache_tag[ptr];
                if (flush_ready) begin
                    clr_valid = 1'b1;
                    clr_dirty = 1'b1;
                    if (ptr == LAST) state_nxt = DONE;
                    else begin
                        ptr_nxt   = ptr + PTR_ONE;
                        state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Controller updates and flush clears never overlap: the former only act in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < N; i++) begin
                valid[i]      <= 1'b0;
                dirty_bits[i] <= 1'b0;
                cache_tag[i]  <= '0;
                age[i]        <= WAY_W'(i % WAYS);
            end
        end else begin
            if (state == IDLE) begin
                if (valid_update) begin
                    valid[entry]      <= 1'b1;
                    cache_tag[entry]  <= cache_tag_update;
                    dirty_bits[entry] <= dirty_bit_update;
                end else if (dirty_bit_update) begin
                    dirty_bits[entry] <= 1'b1;
                end
                if (update_lru) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == way_sel)
                            age[{index, WAY_W'(w)}] <= '0;
                        else if (age[{index, WAY_W'(w)}] < age_old)
                            age[{index, WAY_W'(w)}] <= age[{index, WAY_W'(w)}] + AGE_ONE;
                    end
                end
            end
            if (clr_valid) valid[ptr]      <= 1'b0;
            if (clr_dirty) dirty_bits[ptr] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_meta_array.sv
// tb/tb_cache_meta_array.sv - self-checking bench for cache_meta_array
module tb_cache_meta_array;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic [6:0]   index = '0;
    logic [1:0]   way_sel = '0;
    logic         valid_update = 1'b0;
    logic [10:0]  cache_tag_update = '0;
    logic         dirty_bit_update = 1'b0;
    logic         update_lru = 1'b0;
    logic [511:0] valid;
    logic [10:0]  cache_tag [511:0];
    logic [511:0] dirty_bits;
    logic [1:0]   age [511:0];
    logic         flush_req = 1'b0;
    logic         flush_valid;
    logic [8:0]   flush_index;
    logic [10:0]  flush_tag;
    logic         flush_ready = 1'b0;
    logic         busy;
    logic         flush_done;

    int checks = 0;
    int errors = 0;

    // Model: per-entry state plus a recency list per set (position = age).
    bit          m_v [512];
    bit          m_d [512];
    logic [10:0] m_t [512];
    int          ord [128][4];

    cache_meta_array dut (
        .clk(clk), .rst_b(rst_b), .index(index), .way_sel(way_sel),
        .valid_update(valid_update), .cache_tag_update(cache_tag_update),
        .dirty_bit_update(dirty_bit_update), .update_lru(update_lru),
        .valid(valid), .cache_tag(cache_tag), .dirty_bits(dirty_bits), .age(age),
        .flush_req(flush_req), .flush_valid(flush_valid), .flush_index(flush_index),
        .flush_tag(flush_tag), .flush_ready(flush_ready), .busy(busy), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_age(int s, int w);
        for (int p = 0; p < 4; p++) if (ord[s][p] == w) return p;
        return -1;
    endfunction

    task automatic m_touch(int s, int w);
        int p = m_age(s, w);
        for (int q = p; q > 0; q--) ord[s][q] = ord[s][q-1];
        ord[s][0] = w;
    endtask

    task automatic m_reset();
        for (int e = 0; e < 512; e++) begin
            m_v[e] = 0; m_d[e] = 0; m_t[e] = '0;
        end
        for (int s = 0; s < 128; s++)
            for (int p = 0; p < 4; p++) ord[s][p] = p;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        step();
        step();
        rst_b = 1'b1;
        m_reset();
    endtask

    task automatic upd(int s, int w, bit vu, logic [10:0] t, bit du, bit lru, int n);
        int e = s * 4 + w;
        index = 7'(s); way_sel = 2'(w); valid_update = vu;
        cache_tag_update = t; dirty_bit_update = du; update_lru = lru;
        repeat (n) begin
            step();
            if (vu) begin
                m_v[e] = 1; m_t[e] = t; m_d[e] = du;
            end else if (du) m_d[e] = 1;
            if (lru) m_touch(s, w);
        end
        valid_update = 1'b0; dirty_bit_update = 1'b0; update_lru = 1'b0;
    endtask

    task automatic cmp_all(string name);
        int bad = 0;
        for (int e = 0; e < 512; e++) begin
            if (valid[e] !== m_v[e] || dirty_bits[e] !== m_d[e] || cache_tag[e] !== m_t[e] ||
                age[e] !== 2'(m_age(e / 4, e % 4))) begin
                if (bad == 0)
                    $display("FAIL %s entry %0d: got v%0d d%0d t%h a%0d expected v%0d d%0d t%h a%0d",
                             name, e, valid[e], dirty_bits[e], cache_tag[e], age[e],
                             m_v[e], m_d[e], m_t[e], m_age(e / 4, e % 4));
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    task automatic cmp_set(int s);
        logic [3:0] seen = '0;
        for (int w = 0; w < 4; w++) begin
            int e = s * 4 + w;
            chk($sformatf("valid[%0d]", e), 32'(valid[e]), 32'(m_v[e]));
            chk($sformatf("tag[%0d]", e), 32'(cache_tag[e]), 32'(m_t[e]));
            chk($sformatf("dirty[%0d]", e), 32'(dirty_bits[e]), 32'(m_d[e]));
            chk($sformatf("age[%0d]", e), 32'(age[e]), 32'(m_age(s, w)));
            seen[age[e]] = 1'b1;
        end
        chk($sformatf("perm set %0d", s), 32'(seen), 32'hF);
    endtask

    typedef struct {
        int s; int w; bit vu; logic [10:0] t; bit du; bit lru; int n;
        int e; bit ev; logic [10:0] et; bit ed; int a0; int a1; int a2; int a3;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int cyc;
        tbl[0] = '{5, 2, 1, 11'h2AB, 0, 1, 1, 22, 1, 11'h2AB, 0, 1, 2, 0, 3};
        tbl[1] = '{5, 2, 0, 11'h000, 0, 1, 3, 22, 1, 11'h2AB, 0, 1, 2, 0, 3};
        tbl[2] = '{5, 2, 0, 11'h000, 1, 0, 1, 22, 1, 11'h2AB, 1, 1, 2, 0, 3};
        tbl[3] = '{0, 3, 0, 11'h000, 0, 1, 1, 3, 0, 11'h000, 0, 1, 2, 3, 0};
        tbl[4] = '{0, 0, 0, 11'h000, 0, 1, 1, 0, 0, 11'h000, 0, 0, 2, 3, 1};
        tbl[5] = '{0, 1, 0, 11'h000, 0, 1, 1, 1, 0, 11'h000, 0, 1, 0, 3, 2};
        tbl[6] = '{0, 2, 0, 11'h000, 0, 1, 1, 2, 0, 11'h000, 0, 2, 1, 0, 3};

        do_reset();
        cmp_all("reset arrays");
        for (int w = 0; w < 4; w++) chk($sformatf("reset age[%0d]", 8 + w), 32'(age[8+w]), 32'(w));
        chk("reset busy", 32'(busy), 0);
        chk("reset flush_valid", 32'(flush_valid), 0);
        chk("reset flush_done", 32'(flush_done), 0);
        chk("reset flush_index", 32'(flush_index), 0);
        chk("reset flush_tag", 32'(flush_tag), 0);

        for (int i = 0; i < 7; i++) begin
            int b;
            upd(tbl[i].s, tbl[i].w, tbl[i].vu, tbl[i].t, tbl[i].du, tbl[i].lru, tbl[i].n);
            b = (tbl[i].e / 4) * 4;
            chk($sformatf("vec%0d valid", i), 32'(valid[tbl[i].e]), 32'(tbl[i].ev));
            chk($sformatf("vec%0d tag", i), 32'(cache_tag[tbl[i].e]), 32'(tbl[i].et));
            chk($sformatf("vec%0d dirty", i), 32'(dirty_bits[tbl[i].e]), 32'(tbl[i].ed));
            chk($sformatf("vec%0d ages", i), {24'd0, age[b], age[b+1], age[b+2], age[b+3]},
                {24'd0, 2'(tbl[i].a0), 2'(tbl[i].a1), 2'(tbl[i].a2), 2'(tbl[i].a3)});
            cmp_all($sformatf("vec%0d model", i));
        end

        for (int i = 0; i < 400; i++) begin
            int s = $urandom_range(0, 7);
            upd(s, $urandom_range(0, 3), $urandom_range(0, 3) == 0, 11'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(1, 2));
            cmp_set(s);
            if (i % 100 == 99) cmp_all("random full");
        end

        // Flush with two dirty lines and a stalled write-back.
        do_reset();
        upd(1, 3, 1, 11'h011, 1, 0, 1);
        upd(75, 0, 1, 11'h7FF, 1, 0, 1);
        upd(2, 0, 1, 11'h123, 0, 1, 1);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("flush busy", 32'(busy), 1);
        index = 7'd100; way_sel = 2'd0; valid_update = 1'b1; cache_tag_update = 11'h555;
        dirty_bit_update = 1'b1; flush_req = 1'b1;
        step();
        valid_update = 1'b0; dirty_bit_update = 1'b0; flush_req = 1'b0;
        chk("busy update ignored valid", 32'(valid[400]), 0);
        chk("busy update ignored tag", 32'(cache_tag[400]), 0);
        cyc = 0;
        while (!flush_valid && cyc < 600) begin step(); cyc++; end
        chk("cycles to entry 7", 32'(cyc), 7);
        for (int k = 0; k < 6; k++) begin
            chk("stall flush_valid", 32'(flush_valid), 1);
            chk("stall flush_index", 32'(flush_index), 7);
            chk("stall flush_tag", 32'(flush_tag), 32'h011);
            if (k < 5) step();
        end
        flush_ready = 1'b1;
        step();
        flush_ready = 1'b0;
        chk("drop flush_valid", 32'(flush_valid), 0);
        chk("entry 7 valid cleared", 32'(valid[7]), 0);
        chk("entry 7 dirty cleared", 32'(dirty_bits[7]), 0);
        cyc = 0;
        while (!flush_valid && cyc < 600) begin step(); cyc++; end
        chk("cycles to entry 300", 32'(cyc), 293);
        chk("second flush_index", 32'(flush_index), 300);
        chk("second flush_tag", 32'(flush_tag), 32'h7FF);
        flush_ready = 1'b1;
        step();
        flush_ready = 1'b0;
        cyc = 0;
        while (!flush_done && cyc < 600) begin step(); cyc++; end
        chk("cycles to flush_done", 32'(cyc), 211);
        chk("busy during done", 32'(busy), 1);
        step();
        chk("flush_done single pulse", 32'(flush_done), 0);
        chk("idle after flush", 32'(busy), 0);
        for (int e = 0; e < 512; e++) begin
            if (m_v[e] && m_d[e]) m_d[e] = 0;
            m_v[e] = 0;
        end
        cmp_all("after flush");

        // Reset while a write-back is pending.
        do_reset();
        upd(1, 3, 1, 11'h011, 1, 0, 1);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        cyc = 0;
        while (!flush_valid && cyc < 50) begin step(); cyc++; end
        chk("abort reach WAIT_WB", 32'(cyc), 8);
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        m_reset();
        chk("abort flush_valid", 32'(flush_valid), 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort flush_done", 32'(flush_done), 0);
        chk("abort flush_index", 32'(flush_index), 0);
        repeat (3) begin
            step();
            chk("post-abort flush_done", 32'(flush_done), 0);
            chk("post-abort busy", 32'(busy), 0);
        end
        cmp_all("after abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
